// File: rtl/ula_arbitro_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, widths and the
// round-robin pick helper. The opcode set is common with the ALU core.
package ula_arbitro_seq_pkg;

    localparam int unsigned RESULT_W = 8;
    localparam int unsigned OPND_W   = 4;
    localparam int unsigned CNT_W    = 4;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MULT = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_INV  = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              cin;
    } alu_cmd_t;

    typedef struct packed {
        logic cout;
        logic ov;
        logic z;
        logic err;
    } alu_flags_t;

    // Returns the granted requester: the sole valid one, or on a tie the one not served last.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/ula_arbitro_seq_if.sv
// Request, ALU and response bundle of the ALU sequencer. ULA_SEQ_ACC_EN adds the
// per-requester use_acc inputs.
interface ula_arbitro_seq_if;
    import ula_arbitro_seq_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [2:0]          req0_op;
    logic [OPND_W-1:0]   req0_a;
    logic [OPND_W-1:0]   req0_b;
    logic                req0_cin;

    logic                req1_valid;
    logic                req1_ready;
    logic [2:0]          req1_op;
    logic [OPND_W-1:0]   req1_a;
    logic [OPND_W-1:0]   req1_b;
    logic                req1_cin;

`ifdef ULA_SEQ_ACC_EN
    logic                req0_use_acc;
    logic                req1_use_acc;
`endif

    logic [OPND_W-1:0]   alu_a;
    logic [OPND_W-1:0]   alu_b;
    logic [2:0]          alu_op;
    logic                alu_cin;
    logic [RESULT_W-1:0] alu_result;
    logic                alu_cout;
    logic                alu_ov;
    logic                alu_z;
    logic                alu_err;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [RESULT_W-1:0] rsp_result;
    logic                rsp_cout;
    logic                rsp_ov;
    logic                rsp_z;
    logic                rsp_err;

    // Sequencer side.
    modport slave (
`ifdef ULA_SEQ_ACC_EN
        input  req0_use_acc, req1_use_acc,
`endif
        input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_result, alu_cout, alu_ov, alu_z, alu_err,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ov, rsp_z, rsp_err,
        input  rsp_ready
    );

    // Requester / ALU / consumer side.
    modport master (
`ifdef ULA_SEQ_ACC_EN
        output req0_use_acc, req1_use_acc,
`endif
        output req0_valid, req0_op, req0_a, req0_b, req0_cin,
        output req1_valid, req1_op, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_result, alu_cout, alu_ov, alu_z, alu_err,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ov, rsp_z, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/ula_arbitro_seq_rr.sv
// Two-way round-robin grant. The last-grant pointer starts at 1 so requester 0
// wins the first tie, and it only moves when a grant is accepted.
module ula_rr_arbitro
    import ula_arbitro_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_accept,
    output logic o_grant
);

    logic r_last;

    assign o_grant = rr_pick(i_valid0, i_valid1, r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/ula_arbitro_seq.sv
// Shares one combinational 4-bit ALU between two requesters: arbitrate, hold operands
// for SETTLE_CYCLES (1..15), capture result/flags, return them. Option: ULA_SEQ_ACC_EN.
module ula_arbitro_seq
    import ula_arbitro_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    ula_arbitro_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    alu_cmd_t            r_cmd;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [RESULT_W-1:0] r_rsp_result;
    alu_flags_t          r_rsp_flags;

    logic                w_grant;
    logic                w_ready0;
    logic                w_ready1;
    logic                w_accept;
    logic                w_capture;
    alu_cmd_t            w_cmd;

    ula_rr_arbitro u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Ready is offered only in IDLE, and only to the granted requester.
    assign w_ready0  = (r_state == StIdle) && !w_grant && bus.req0_valid;
    assign w_ready1  = (r_state == StIdle) &&  w_grant && bus.req1_valid;
    assign w_accept  = w_ready0 || w_ready1;
    assign w_capture = (r_state == StExec) && (r_cnt == CNT_W'(1));

`ifdef ULA_SEQ_ACC_EN
    logic [OPND_W-1:0] r_acc;
    logic              w_use_acc;

    assign w_use_acc = w_grant ? bus.req1_use_acc : bus.req0_use_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_capture) begin
            r_acc <= bus.alu_result[OPND_W-1:0];
        end
    end
`endif

    always_comb begin
        w_cmd = '0;
        if (w_grant) begin
            w_cmd.op  = bus.req1_op;
            w_cmd.a   = bus.req1_a;
            w_cmd.b   = bus.req1_b;
            w_cmd.cin = bus.req1_cin;
        end else begin
            w_cmd.op  = bus.req0_op;
            w_cmd.a   = bus.req0_a;
            w_cmd.b   = bus.req0_b;
            w_cmd.cin = bus.req0_cin;
        end
`ifdef ULA_SEQ_ACC_EN
        if (w_use_acc) begin
            w_cmd.a = r_acc;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cmd    <= w_cmd;
                        r_rsp_id <= w_grant;
                        r_cnt    <= SETTLE_LD;
                        r_state  <= StExec;
                    end
                end
                StExec: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_capture) begin
                        r_rsp_result     <= bus.alu_result;
                        r_rsp_flags.cout <= bus.alu_cout;
                        r_rsp_flags.ov   <= bus.alu_ov;
                        r_rsp_flags.z    <= bus.alu_z;
                        r_rsp_flags.err  <= bus.alu_err;
                        r_rsp_valid      <= 1'b1;
                        r_state          <= StResp;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;

    assign bus.alu_a   = r_cmd.a;
    assign bus.alu_b   = r_cmd.b;
    assign bus.alu_op  = r_cmd.op;
    assign bus.alu_cin = r_cmd.cin;

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_cout   = r_rsp_flags.cout;
    assign bus.rsp_ov     = r_rsp_flags.ov;
    assign bus.rsp_z      = r_rsp_flags.z;
    assign bus.rsp_err    = r_rsp_flags.err;

endmodule

// File: tb/tb_ula_arbitro_seq.sv
// Scoreboard bench for ula_arbitro_seq: directed requests push expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_ula_arbitro_seq;
    import ula_arbitro_seq_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] result;
        logic       cout;
        logic       ov;
        logic       z;
        logic       err;
    } rsp_t;

    typedef struct packed {
        logic [7:0] result;
        logic       cout;
        logic       ov;
        logic       z;
        logic       err;
    } alu_out_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst4 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

`ifdef ULA_SEQ_ACC_EN
    logic tb_use_acc = 1'b0;
`endif

    always #5 clk = ~clk;

    ula_arbitro_seq_if bus ();
    ula_arbitro_seq_if bus4 ();

    ula_arbitro_seq #(.SETTLE_CYCLES(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ula_arbitro_seq #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    // Stand-in for the combinational ALU core.
    function automatic alu_out_t alu_model(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
        alu_out_t o;
        logic [4:0] t;
        o = '0;
        t = '0;
        case (op)
            OP_SOMA: begin
                t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                o.result = {4'h0, t[3:0]};
                o.cout = t[4];
                o.ov = (a[3] == b[3]) && (t[3] != a[3]);
            end
            OP_SUB: begin
                t = {1'b0, a} - {1'b0, b} - {4'b0, cin};
                o.result = {4'h0, t[3:0]};
                o.cout = t[4];
                o.ov = (a[3] != b[3]) && (t[3] != a[3]);
            end
            OP_AND:  o.result = {4'h0, a & b};
            OP_OR:   o.result = {4'h0, a | b};
            OP_XOR:  o.result = {4'h0, a ^ b};
            OP_MULT: o.result = {4'h0, a} * {4'h0, b};
            OP_DIV: begin
                if (b == 4'h0) o.err = 1'b1;
                else o.result = {4'h0, a / b};
            end
            OP_INV:  o.result = 8'h00;
            default: o.result = 8'h00;
        endcase
        o.z = (o.result == 8'h00);
        return o;
    endfunction

    alu_out_t alu_o, alu4_o;
    always_comb alu_o  = alu_model(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
    always_comb alu4_o = alu_model(bus4.alu_op, bus4.alu_a, bus4.alu_b, bus4.alu_cin);
    assign bus.alu_result  = alu_o.result;
    assign bus.alu_cout    = alu_o.cout;
    assign bus.alu_ov      = alu_o.ov;
    assign bus.alu_z       = alu_o.z;
    assign bus.alu_err     = alu_o.err;
    assign bus4.alu_result = alu4_o.result;
    assign bus4.alu_cout   = alu4_o.cout;
    assign bus4.alu_ov     = alu4_o.ov;
    assign bus4.alu_z      = alu4_o.z;
    assign bus4.alu_err    = alu4_o.err;

    logic [27:0] outs_main, outs4;
    assign outs_main = {bus.req0_ready, bus.req1_ready, bus.alu_a, bus.alu_b, bus.alu_op,
                        bus.alu_cin, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cout,
                        bus.rsp_ov, bus.rsp_z, bus.rsp_err};
    assign outs4 = {bus4.req0_ready, bus4.req1_ready, bus4.alu_a, bus4.alu_b, bus4.alu_op,
                    bus4.alu_cin, bus4.rsp_valid, bus4.rsp_id, bus4.rsp_result, bus4.rsp_cout,
                    bus4.rsp_ov, bus4.rsp_z, bus4.rsp_err};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [7:0] res, input logic cout,
                        input logic ov, input logic z, input logic err);
        rsp_t e;
        e = {id, res, cout, ov, z, err};
        exp_q.push_back(e);
    endtask

    task automatic send(input logic id, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic cin);
        int n;
        @(negedge clk);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
`ifdef ULA_SEQ_ACC_EN
            bus.req1_use_acc = tb_use_acc;
`endif
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
`ifdef ULA_SEQ_ACC_EN
            bus.req0_use_acc = tb_use_acc;
`endif
            bus.req0_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req%0d ready stayed 0, required 1", id);
        end
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // Response monitor
    always @(negedge clk) begin : mon
        rsp_t got;
        rsp_t exp;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            got = {bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_ov, bus.rsp_z, bus.rsp_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d res=0x%02h, required none",
                         got.id, got.result);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d res=0x%02h c=%0b v=%0b z=%0b e=%0b, required id=%0d res=0x%02h c=%0b v=%0b z=%0b e=%0b",
                             got.id, got.result, got.cout, got.ov, got.z, got.err,
                             exp.id, exp.result, exp.cout, exp.ov, exp.z, exp.err);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int  n;
        logic saw;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
        bus4.req0_valid = 0; bus4.req0_op = 0; bus4.req0_a = 0; bus4.req0_b = 0;
        bus4.req0_cin = 0;
        bus4.req1_valid = 0; bus4.req1_op = 0; bus4.req1_a = 0; bus4.req1_b = 0;
        bus4.req1_cin = 0;
`ifdef ULA_SEQ_ACC_EN
        bus.req0_use_acc = 0; bus.req1_use_acc = 0;
        bus4.req0_use_acc = 0; bus4.req1_use_acc = 0;
`endif
        bus.rsp_ready = 1'b1;
        bus4.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs_main), 0);
        chk("reset_outputs4", 32'(outs4), 0);
        rst = 1'b0;
        rst4 = 1'b0;

        // Tie out of reset: req0 first, then req1.
        push(1'b0, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            send(1'b0, OP_SUB, 4'd3, 4'd5, 1'b0);
            send(1'b1, OP_MULT, 4'd15, 4'd15, 1'b0);
        join
        wait_idle();

        // Single SOMA with one-cycle settle.
        push(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, OP_SOMA, 4'd7, 4'd8, 1'b0);
        @(negedge clk);
        chk("t1_rsp_valid_exec", 32'(bus.rsp_valid), 0);
        chk("t1_alu_ab", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'({4'd7, 4'd8, OP_SOMA}));
        @(negedge clk);
        chk("t1_latency", 32'(bus.rsp_valid), 1);
        wait_idle();

        // DIV by zero, then AND, from req1 alone.
        push(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        send(1'b1, OP_DIV, 4'd9, 4'd0, 1'b0);
        push(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, OP_AND, 4'd12, 4'd10, 1'b0);
        wait_idle();

        // Response back-pressure with a pending req0.
        bus.rsp_ready = 1'b0;
        push(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, OP_OR, 4'd5, 4'd3, 1'b0);
        push(1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            send(1'b0, OP_XOR, 4'd6, 4'd3, 1'b0);
        join_none
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL t4_rsp_timeout: rsp_valid stayed 0, required 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cout,
                                    bus.rsp_ov, bus.rsp_z, bus.rsp_err}),
                32'({1'b1, 1'b1, 8'h07, 4'b0000}));
            chk("t4_hold_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}),
                32'({4'd5, 4'd3, OP_OR, 1'b0}));
            chk("t4_ready_low", 32'({bus.req0_ready, bus.req1_ready}), 0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_accept_at_handshake", 32'(bus.req0_ready), 0);
        @(negedge clk);
        chk("t4_valid_cleared", 32'(bus.rsp_valid), 0);
        chk("t4_accept_next_cycle", 32'(bus.req0_ready), 1);
        wait_idle();

        // Tie after req0 was served last: req1 wins.
        push(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            send(1'b0, OP_AND, 4'd15, 4'd6, 1'b0);
            send(1'b1, OP_XOR, 4'd15, 4'd0, 1'b0);
        join
        wait_idle();

        // Invalid opcode is forwarded.
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, OP_INV, 4'd3, 4'd4, 1'b0);
        @(negedge clk);
        chk("inv_forwarded", 32'(bus.alu_op), 32'(OP_INV));
        wait_idle();

`ifdef ULA_SEQ_ACC_EN
        push(1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, OP_OR, 4'd0, 4'd5, 1'b0);
        tb_use_acc = 1'b1;
        push(1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, OP_SOMA, 4'd9, 4'd3, 1'b0);
        tb_use_acc = 1'b0;
        wait_idle();
`endif

        // Four-cycle settle latency.
        @(negedge clk);
        bus4.req0_op = OP_SOMA; bus4.req0_a = 4'd2; bus4.req0_b = 4'd3; bus4.req0_cin = 1'b0;
        bus4.req0_valid = 1'b1;
        #1;
        chk("t5_ready", 32'(bus4.req0_ready), 1);
        @(posedge clk);
        #1;
        bus4.req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_settle_wait", 32'(bus4.rsp_valid), 0);
        end
        @(negedge clk);
        chk("t5_latency", 32'({bus4.rsp_valid, bus4.rsp_result}), 32'({1'b1, 8'h05}));
        @(negedge clk);
        chk("t5_consumed", 32'(bus4.rsp_valid), 0);

        // Reset mid-EXEC aborts the operation.
        bus4.req0_a = 4'd1; bus4.req0_b = 4'd1;
        bus4.req0_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_alu_loaded", 32'(bus4.alu_a), 1);
        #2;
        rst4 = 1'b1;
        #1;
        chk("t5_async_reset", 32'(outs4), 0);
        @(negedge clk);
        rst4 = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus4.rsp_valid) saw = 1'b1;
        end
        chk("t5_no_rsp_after_reset", 32'(saw), 0);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
